ctrl_pipe_chain: RTL and testbench
==================================

# ctrl_pipe_chain

Parametrised control-signal pipeline that carries a WIDTH-bit decoded control bundle from decode through STAGES downstream pipeline stages (E, M, W, ... for the MIPS core). Each stage has its own stall, flush and kill input. A stall propagates upstream automatically, and bubbles are inserted downstream of a held stage. The block also keeps a saturating retire counter. It replaces the hand-written per-stage control registers in the core controller, so the same block serves 3-stage and deeper pipelines.

## Interface
- WIDTH, 16: bits per control bundle.
- STAGES, 3: number of pipeline register stages; must be ≥1. Stage 0 is E, and stage STAGES-1 is the last stage.
- KILL_MASK, 16'h0000: bits cleared in a bundle entering a stage whose kill input is high, for example the regwrite bit on overflow.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset.
- in_data  in  WIDTH  decode-stage bundle.
- in_valid  in  1  in_data holds a real instruction.
- stall  in  STAGES  stall[i] requests stage i to hold.
- flush  in  STAGES  flush[i] clears stage i to a bubble.
- kill  in  STAGES  kill[i] applies KILL_MASK to the bundle loading into stage i.
- out_data  out  STAGES*WIDTH  stage i bundle at bits [i*WIDTH +: WIDTH].
- out_valid  out  STAGES  stage i holds a valid entry.
- retire_cnt  out  32  count of valid entries leaving the last stage; saturating.

## Operation
- Effective hold: hold[i] = OR of stall[j] for j ≥ i. A stall holds its own stage and every upstream stage.
- Decode accept: the upstream stall output is hold[0]. While hold[0]=1, in_data and in_valid are not captured and the caller keeps them stable.
- Per-stage update for stage i, in priority order:
  - flush[i]: stage i loads zero data with valid 0. This applies even if hold[i]=1.
  - hold[i]: stage i keeps its contents. kill[i] is ignored.
  - i>0 and hold[i-1]=1 while hold[i]=0: bubble. Stage i loads zero data with valid 0.
  - otherwise: stage i loads its source.
- Source for a load:
  - Stage 0 loads from in_data and in_valid.
  - Stage i loads from stage i-1.
  - If kill[i]=1, the loaded data is source & ~KILL_MASK. Valid is unchanged.
- Invariant: out_valid[i]=0 implies the stage i slice of out_data is all zero. An invalid source loads zero data.
- Flush does not alter hold. A flushed stage inside a held region stays a bubble, and upstream stages still hold.
- retire_cnt:
  - Increments by 1 in a cycle when out_valid[STAGES-1]=1, hold[STAGES-1]=0 and flush[STAGES-1]=0.
  - Stops at 32'hFFFF_FFFF.

## Timing
- Reset: rst=0 at a rising edge clears out_data and out_valid to all 0 and retire_cnt to 0. This applies mid-operation, and rst overrides stall, flush and kill.
- Latency: a bundle accepted at edge n appears at stage i output after edge n+i, provided no holds occur. That is i+1 cycles after it was presented.
- Outputs are registered; there is no combinational path from inputs to out_data, out_valid or retire_cnt.
- Flush, kill and stall are sampled at the same edge as the data they affect.
- retire_cnt reflects a retirement one cycle after it occurs.
- STAGES=1: hold[0]=stall[0] and no bubbles are inserted.

## Test plan
- Streaming (WIDTH=16, STAGES=3, KILL_MASK=16'h0800):
  - Stimulus: feed 16'h1111, 16'h2222, 16'h3333 with in_valid=1 on consecutive cycles.
  - Required: out_data stage 2 shows 1111/2222/3333 on cycles 3/4/5, out_valid[2]=1, and retire_cnt ends at 3.
- Stall propagation:
  - Stimulus: stall[1]=1 for 2 cycles with stages holding A,B,C.
  - Required: stages 0 and 1 hold A and B, stage 2 becomes a bubble (data 0, valid 0) on both cycles, and retire_cnt increments only once (for C).
- Flush versus stall:
  - Stimulus: flush[1]=1 and stall[1]=1 in the same cycle.
  - Required: stage 1 becomes 0/valid 0, stage 0 holds, and stage 2 loads a bubble.
- Kill:
  - Stimulus: kill[1]=1 as stage 0 (16'h0FFF) advances.
  - Required: stage 1 shows 16'h07FF with valid 1.
  - Stimulus: kill[1]=1 while hold[1]=1.
  - Required: stage 1 is unchanged.
- Reset mid-stream:
  - Stimulus: rst=0 for one edge with all stages valid and retire_cnt=5.
  - Required: all outputs read 0 on the next cycle, and a bundle fed afterwards emerges at stage 2 three cycles later.
- Saturation:
  - Stimulus: force retire_cnt to 32'hFFFF_FFFE and retire 3 entries.
  - Required: retire_cnt reads 32'hFFFF_FFFF and stays there.

Source files
------------

// File: rtl/ctrl_pipe_chain.sv
// Control-bundle pipeline: carries a decoded bundle through STAGES registered stages with
// per-stage stall/flush/kill, automatic upstream stall propagation and a saturating retire counter.
module ctrl_pipe_chain #(
  parameter int               WIDTH     = 16,
  parameter int               STAGES    = 3,
  parameter logic [WIDTH-1:0] KILL_MASK = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  input  logic [STAGES-1:0]        stall,
  input  logic [STAGES-1:0]        flush,
  input  logic [STAGES-1:0]        kill,
  output logic [STAGES*WIDTH-1:0]  out_data,
  output logic [STAGES-1:0]        out_valid,
  output logic [31:0]              retire_cnt,
  output logic                     in_stall
);

  logic [STAGES-1:0] hold;
  logic [STAGES-1:0] bubble;
  logic              retireEvent;
  logic [31:0]       retireCnt;

  // A stall holds its own stage and everything upstream of it.
  always_comb begin
    hold = '0;
    hold[STAGES-1] = stall[STAGES-1];
    for (int i = STAGES - 2; i >= 0; i--) begin
      hold[i] = stall[i] | hold[i+1];
    end
  end

  always_comb begin
    bubble = '0;
    for (int i = 1; i < STAGES; i++) begin
      bubble[i] = hold[i-1] & ~hold[i];
    end
  end

  // Decode must keep in_data/in_valid stable while this is high.
  assign in_stall = hold[0];

  for (genvar g = 0; g < STAGES; g++) begin : gStage
    logic [WIDTH-1:0] rawData;
    logic             rawValid;
    logic [WIDTH-1:0] loadData;
    logic [WIDTH-1:0] dataQ;
    logic             validQ;

    if (g == 0) begin : gSrcDecode
      assign rawData  = in_data;
      assign rawValid = in_valid;
    end else begin : gSrcPrev
      assign rawData  = gStage[g-1].dataQ;
      assign rawValid = gStage[g-1].validQ;
    end

    // Invalid entries always carry zero data so downstream logic never sees stale bits.
    assign loadData = !rawValid ? '0 :
                      (kill[g] ? (rawData & ~KILL_MASK) : rawData);

    always_ff @(posedge clk) begin
      if (!rst) begin
        dataQ  <= '0;
        validQ <= 1'b0;
      end else if (flush[g]) begin
        dataQ  <= '0;
        validQ <= 1'b0;
      end else if (hold[g]) begin
        dataQ  <= dataQ;
        validQ <= validQ;
      end else if (bubble[g]) begin
        dataQ  <= '0;
        validQ <= 1'b0;
      end else begin
        dataQ  <= loadData;
        validQ <= rawValid;
      end
    end

    assign out_data[g*WIDTH +: WIDTH] = dataQ;
    assign out_valid[g]               = validQ;
  end

  assign retireEvent = out_valid[STAGES-1] & ~hold[STAGES-1] & ~flush[STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst) begin
      retireCnt <= '0;
    end else if (retireEvent && (retireCnt != 32'hFFFF_FFFF)) begin
      retireCnt <= retireCnt + 32'd1;
    end
  end

  assign retire_cnt = retireCnt;

endmodule

// File: tb/tb_ctrl_pipe_chain.sv
// Bench for ctrl_pipe_chain (WIDTH=16, STAGES=3, KILL_MASK=16'h0800): directed vector table,
// saturation sequence and randomized traffic compared with a behavioural pipeline model.
module tb_ctrl_pipe_chain;

  localparam int          W    = 16;
  localparam int          S    = 3;
  localparam logic [15:0] MASK = 16'h0800;

  logic          clk;
  logic          rst;
  logic [W-1:0]  in_data;
  logic          in_valid;
  logic [S-1:0]  stall;
  logic [S-1:0]  flush;
  logic [S-1:0]  kill;
  logic [S*W-1:0] out_data;
  logic [S-1:0]  out_valid;
  logic [31:0]   retire_cnt;
  logic          in_stall;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];

  ctrl_pipe_chain #(.WIDTH(W), .STAGES(S), .KILL_MASK(MASK)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .stall      (stall),
    .flush      (flush),
    .kill       (kill),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .retire_cnt (retire_cnt),
    .in_stall   (in_stall)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural model: a 3-entry pipeline described by its advance rules
  logic [W-1:0] m_d[S];
  logic         m_v[S];
  logic [31:0]  m_cnt;

  task automatic model_step();
    logic         h[S];
    logic [W-1:0] nd[S];
    logic         nv[S];
    logic [W-1:0] sd;
    logic         sv;
    if (!rst) begin
      for (int i = 0; i < S; i++) begin
        m_d[i] = '0;
        m_v[i] = 1'b0;
      end
      m_cnt = 0;
      return;
    end
    for (int i = 0; i < S; i++) begin
      h[i] = 1'b0;
      for (int j = i; j < S; j++) if (stall[j]) h[i] = 1'b1;
    end
    if (m_v[S-1] && !h[S-1] && !flush[S-1] && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    for (int i = 0; i < S; i++) begin
      sd = (i == 0) ? in_data  : m_d[i-1];
      sv = (i == 0) ? in_valid : m_v[i-1];
      if (flush[i]) begin
        nd[i] = '0; nv[i] = 1'b0;
      end else if (h[i]) begin
        nd[i] = m_d[i]; nv[i] = m_v[i];
      end else if (i > 0 && h[i-1]) begin
        nd[i] = '0; nv[i] = 1'b0;
      end else begin
        nv[i] = sv;
        nd[i] = !sv ? '0 : (kill[i] ? (sd & ~MASK) : sd);
      end
    end
    for (int i = 0; i < S; i++) begin
      m_d[i] = nd[i];
      m_v[i] = nv[i];
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, " data"},  {16'h0, out_data}, {16'h0, m_d[2], m_d[1], m_d[0]});
    check({tag, " valid"}, {61'h0, out_valid}, {61'h0, m_v[2], m_v[1], m_v[0]});
    check({tag, " cnt"},   {32'h0, retire_cnt}, {32'h0, m_cnt});
  endtask

  // driver tasks: called at a falling edge
  task automatic drive(input logic r, input logic [W-1:0] d, input logic v,
                       input logic [S-1:0] st, input logic [S-1:0] fl, input logic [S-1:0] kl);
    rst = r; in_data = d; in_valid = v; stall = st; flush = fl; kill = kl;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  typedef struct {
    logic         r;
    logic [W-1:0] din;
    logic         vin;
    logic [S-1:0] st;
    logic [S-1:0] fl;
    logic [S-1:0] kl;
    logic [S*W-1:0] exp_data;
    logic [S-1:0] exp_valid;
    logic [31:0]  exp_cnt;
  } vec_t;

  vec_t vq[$];

  task automatic add_vec(input logic r, input logic [W-1:0] din, input logic vin,
                         input logic [S-1:0] st, input logic [S-1:0] fl, input logic [S-1:0] kl,
                         input logic [W-1:0] s2, input logic [W-1:0] s1, input logic [W-1:0] s0,
                         input logic [S-1:0] ev, input logic [31:0] cnt);
    vec_t v;
    v.r = r; v.din = din; v.vin = vin; v.st = st; v.fl = fl; v.kl = kl;
    v.exp_data = {s2, s1, s0}; v.exp_valid = ev; v.exp_cnt = cnt;
    vq.push_back(v);
  endtask

  initial begin
    drive(1'b0, '0, 1'b0, '0, '0, '0);
    for (int i = 0; i < S; i++) begin
      m_d[i] = '0;
      m_v[i] = 1'b0;
    end
    m_cnt = 0;

    //      r  din      v  stall   flush   kill    s2       s1       s0       valid   cnt
    add_vec(0, 16'h0000, 0, 3'b000, 3'b000, 3'b000, 16'h0000, 16'h0000, 16'h0000, 3'b000, 0);
    // streaming
    add_vec(1, 16'h1111, 1, 3'b000, 3'b000, 3'b000, 16'h0000, 16'h0000, 16'h1111, 3'b001, 0);
    add_vec(1, 16'h2222, 1, 3'b000, 3'b000, 3'b000, 16'h0000, 16'h1111, 16'h2222, 3'b011, 0);
    add_vec(1, 16'h3333, 1, 3'b000, 3'b000, 3'b000, 16'h1111, 16'h2222, 16'h3333, 3'b111, 0);
    add_vec(1, 16'h0000, 0, 3'b000, 3'b000, 3'b000, 16'h2222, 16'h3333, 16'h0000, 3'b110, 1);
    add_vec(1, 16'h0000, 0, 3'b000, 3'b000, 3'b000, 16'h3333, 16'h0000, 16'h0000, 3'b100, 2);
    add_vec(1, 16'h0000, 0, 3'b000, 3'b000, 3'b000, 16'h0000, 16'h0000, 16'h0000, 3'b000, 3);
    // stall propagation: A/B/C in stages 0/1/2, then stall[1] for two cycles
    add_vec(1, 16'hCCCC, 1, 3'b000, 3'b000, 3'b000, 16'h0000, 16'h0000, 16'hCCCC, 3'b001, 3);
    add_vec(1, 16'hBBBB, 1, 3'b000, 3'b000, 3'b000, 16'h0000, 16'hCCCC, 16'hBBBB, 3'b011, 3);
    add_vec(1, 16'hAAAA, 1, 3'b000, 3'b000, 3'b000, 16'hCCCC, 16'hBBBB, 16'hAAAA, 3'b111, 3);
    add_vec(1, 16'hDDDD, 1, 3'b010, 3'b000, 3'b000, 16'h0000, 16'hBBBB, 16'hAAAA, 3'b011, 4);
    add_vec(1, 16'hDDDD, 1, 3'b010, 3'b000, 3'b000, 16'h0000, 16'hBBBB, 16'hAAAA, 3'b011, 4);
    add_vec(1, 16'hDDDD, 1, 3'b000, 3'b000, 3'b000, 16'hBBBB, 16'hAAAA, 16'hDDDD, 3'b111, 4);
    // flush and stall on stage 1 together
    add_vec(1, 16'hEEEE, 1, 3'b010, 3'b010, 3'b000, 16'h0000, 16'h0000, 16'hDDDD, 3'b001, 5);
    add_vec(1, 16'h0000, 0, 3'b000, 3'b000, 3'b000, 16'h0000, 16'hDDDD, 16'h0000, 3'b010, 5);
    // kill on advance, then kill while held
    add_vec(1, 16'h0FFF, 1, 3'b000, 3'b000, 3'b000, 16'hDDDD, 16'h0000, 16'h0FFF, 3'b101, 5);
    add_vec(1, 16'h0000, 0, 3'b000, 3'b000, 3'b010, 16'h0000, 16'h07FF, 16'h0000, 3'b010, 6);
    add_vec(1, 16'h0000, 0, 3'b010, 3'b000, 3'b010, 16'h0000, 16'h07FF, 16'h0000, 3'b010, 6);
    add_vec(1, 16'h0000, 0, 3'b100, 3'b000, 3'b011, 16'h0000, 16'h07FF, 16'h0000, 3'b010, 6);
    // fill all stages, then reset with every control asserted
    add_vec(1, 16'h1234, 1, 3'b000, 3'b000, 3'b000, 16'h07FF, 16'h0000, 16'h1234, 3'b101, 6);
    add_vec(1, 16'h5678, 1, 3'b000, 3'b000, 3'b000, 16'h0000, 16'h1234, 16'h5678, 3'b011, 7);
    add_vec(1, 16'h9ABC, 1, 3'b000, 3'b000, 3'b000, 16'h1234, 16'h5678, 16'h9ABC, 3'b111, 7);
    add_vec(0, 16'h4321, 1, 3'b111, 3'b111, 3'b111, 16'h0000, 16'h0000, 16'h0000, 3'b000, 0);
    add_vec(1, 16'hBEEF, 1, 3'b000, 3'b000, 3'b000, 16'h0000, 16'h0000, 16'hBEEF, 3'b001, 0);
    add_vec(1, 16'h0000, 0, 3'b000, 3'b000, 3'b000, 16'h0000, 16'hBEEF, 16'h0000, 3'b010, 0);
    add_vec(1, 16'h0000, 0, 3'b000, 3'b000, 3'b000, 16'hBEEF, 16'h0000, 16'h0000, 3'b100, 0);
    add_vec(1, 16'h0000, 0, 3'b000, 3'b000, 3'b000, 16'h0000, 16'h0000, 16'h0000, 3'b000, 1);
    // kill on the last stage; invalid input with nonzero data
    add_vec(1, 16'h0FFF, 1, 3'b000, 3'b000, 3'b000, 16'h0000, 16'h0000, 16'h0FFF, 3'b001, 1);
    add_vec(1, 16'h0000, 0, 3'b000, 3'b000, 3'b100, 16'h0000, 16'h0FFF, 16'h0000, 3'b010, 1);
    add_vec(1, 16'h0000, 0, 3'b000, 3'b000, 3'b100, 16'h07FF, 16'h0000, 16'h0000, 3'b100, 1);
    add_vec(1, 16'h0000, 0, 3'b000, 3'b000, 3'b000, 16'h0000, 16'h0000, 16'h0000, 3'b000, 2);
    add_vec(1, 16'hFFFF, 0, 3'b000, 3'b000, 3'b000, 16'h0000, 16'h0000, 16'h0000, 3'b000, 2);

    @(negedge clk);
    foreach (vq[k]) begin
      drive(vq[k].r, vq[k].din, vq[k].vin, vq[k].st, vq[k].fl, vq[k].kl);
      #1;
      check($sformatf("vec%0d in_stall", k), {63'h0, in_stall}, {63'h0, |vq[k].st});
      tick();
      check($sformatf("vec%0d data", k),  {16'h0, out_data},   {16'h0, vq[k].exp_data});
      check($sformatf("vec%0d valid", k), {61'h0, out_valid},  {61'h0, vq[k].exp_valid});
      check($sformatf("vec%0d cnt", k),   {32'h0, retire_cnt}, {32'h0, vq[k].exp_cnt});
    end

    // saturation: preload the counter near its ceiling, then retire three bundles
    drive(1'b0, '0, 1'b0, '0, '0, '0);
    tick();
    drive(1'b1, '0, 1'b0, '0, '0, '0);
    force dut.retireCnt = 32'hFFFF_FFFE;
    #1;
    release dut.retireCnt;
    m_cnt = 32'hFFFF_FFFE;
    check("sat preload", {32'h0, retire_cnt}, {32'h0, 32'hFFFF_FFFE});
    for (int n = 0; n < 8; n++) begin
      logic [W-1:0] d;
      d = W'($urandom_range(1, 16'hFFFF));
      if (n < 3) begin
        drive(1'b1, d, 1'b1, '0, '0, '0);
        exp_q.push_back(d);
      end else begin
        drive(1'b1, '0, 1'b0, '0, '0, '0);
      end
      tick();
      check_model("sat");
      if (out_valid[S-1]) begin
        if (exp_q.size() == 0) begin
          check("sat unexpected retire", {63'h0, out_valid[S-1]}, 64'h0);
        end else begin
          check("sat order", {48'h0, out_data[S*W-1 -: W]}, {48'h0, exp_q.pop_front()});
        end
      end
    end
    check("sat queue drained", 64'(exp_q.size()), 64'h0);
    check("sat final", {32'h0, retire_cnt}, {32'h0, 32'hFFFF_FFFF});

    // randomized traffic against the model
    drive(1'b0, '0, 1'b0, '0, '0, '0);
    tick();
    for (int n = 0; n < 400; n++) begin
      logic [S-1:0] st, fl, kl;
      for (int i = 0; i < S; i++) begin
        st[i] = ($urandom_range(0, 3) == 0);
        fl[i] = ($urandom_range(0, 7) == 0);
        kl[i] = ($urandom_range(0, 3) == 0);
      end
      drive(($urandom_range(0, 49) != 0), W'($urandom), $urandom_range(0, 1) == 1, st, fl, kl);
      #1;
      check("rand in_stall", {63'h0, in_stall}, {63'h0, |st});
      tick();
      check_model("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
